symbol_seq_fsm: RTL
===================

// Module: symbol_seq_fsm
// PURPOSE
//   Parametrised, programmable symbol-sequence detector FSM; generalises the fixed 5-state 2-bit FSM.
//   Pattern, pattern length and overlap mode are configured at run time.
//   It consumes a valid-qualified symbol stream and pulses on each complete match.
//   It optionally keeps a saturating match count. It sits between the stimulus/input logic and downstream control.
// PARAMETERS
//   SYM_W    2   symbol width in bits
//   SEQ_LEN  5   maximum pattern length (number of pattern slots); >= 2
//   CNT_W    8   match-counter width (only used with MATCH_CNT_EN)
// PORTS
//   clk         in   1                     system clock, rising edge
//   reset_n     in   1                     asynchronous active-low reset
//   in_valid    in   1                     in_sym is sampled this cycle
//   in_sym      in   SYM_W                 input symbol
//   cfg_we      in   1                     write cfg_sym into pattern slot cfg_idx
//   cfg_idx     in   $clog2(SEQ_LEN)       pattern slot index
//   cfg_sym     in   SYM_W                 pattern symbol to write
//   cfg_len_we  in   1                     load the length register from cfg_len
//   cfg_len     in   $clog2(SEQ_LEN+1)     active pattern length, 0..SEQ_LEN
//   overlap_en  in   1                     1 = overlapping matches allowed
//   match       out  1                     one-cycle pulse per detected sequence
//   state_out   out  $clog2(SEQ_LEN+1)     current progress index (symbols matched so far)
//   match_cnt   out  CNT_W                 saturating match count
//   cnt_sat     out  1                     match_cnt has reached all-ones
// BEHAVIOUR
//   Reset (async, reset_n=0):
//   - pat[] = 0, len_q = SEQ_LEN, st = 0.
//   - match = 0, match_cnt = 0, cnt_sat = 0; all outputs go low immediately.
//   State:
//   - st is 0..len_q-1; state_out = st.
//   - IDLE/DISABLED when len_q == 0: st held at 0, match never asserts.
//   Symbol step (in_valid=1, no config write this cycle, len_q != 0):
//   - hit = (in_sym == pat[st]).
//   - hit and st+1 < len_q: st <= st+1.
//   - hit and st+1 == len_q: match <= 1 next cycle (1-cycle latency from the completing symbol edge).
//     The next state is then:
//     - overlap_en=0: st <= 0.
//     - overlap_en=1: st <= (in_sym == pat[0]) ? 1 : 0.
//   - miss: st <= (in_sym == pat[0]) ? 1 : 0 (simple restart; no full prefix fallback).
//   - len_q == 1: every symbol equal to pat[0] produces a match; st stays 0.
//   - in_valid=0: st holds, match <= 0.
//   Configuration:
//   - Any cfg_we or cfg_len_we forces st <= 0 and match <= 0.
//   - An in_valid asserted in the same cycle is dropped; configuration wins.
//   - cfg_len > SEQ_LEN is clamped to SEQ_LEN.
//   - cfg_idx >= SEQ_LEN: the write is ignored.
//   - overlap_en is sampled each cycle and needs no write strobe.
//   Counter:
//   - match_cnt increments on each cycle where match is 1.
//   - It saturates at 2^CNT_W-1; cnt_sat = (match_cnt == all-ones).
//   - Cleared only by reset.
// CONFIGURATION
//   MATCH_CNT_EN defined:     match counter and cnt_sat are implemented.
//   MATCH_CNT_EN not defined: match_cnt = 0 and cnt_sat = 0 (constant); no counter flops are built.
//   match and state behaviour are identical in both builds.
// STRUCTURE
//   Package symbol_seq_pkg:
//   - width helper localparams / function for IDX_W = $clog2(SEQ_LEN+1).
//   - default SYM_W/SEQ_LEN/CNT_W constants.
//   Sub-module sat_counter (CNT_W, inc, cnt, sat):
//   - instantiated only under MATCH_CNT_EN.
//   The FSM, pattern registers and length register stay in symbol_seq_fsm.
// TESTING (SYM_W=2, SEQ_LEN=5, CNT_W=2 unless noted; pattern {00,01,10,11}, len 4)
//   1. Reset mid-sequence.
//      - Stimulus: drive reset_n=0 asynchronously after symbols 00,01.
//      - Response: st=0, match=0, match_cnt=0 before the next clk edge.
//   2. Exact match, overlap_en=0.
//      - Stimulus: feed 00,01,10,11.
//      - Response: match=1 exactly one cycle after the 11 edge; then st=0, match_cnt=1.
//   3. Mismatch restart.
//      - Stimulus: feed 00,01,00,01,10,11.
//      - Response: st goes 1,2,1,2,3, then match fires after the 6th symbol.
//   4. Overlap mode, pattern {01,01} len 2.
//      - Stimulus: feed 01,01,01.
//      - Response: overlap_en=1 gives 2 match pulses; overlap_en=0 gives 1 pulse.
//   5. Stalls and config collision.
//      - Stimulus A: in_valid=0 cycles between symbols.
//        Response A: st holds and the match occurs as in test 2.
//      - Stimulus B: cfg_we together with in_valid.
//        Response B: the symbol is dropped and st=0.
//   6. Counter saturation, MATCH_CNT_EN defined, len 1, pat[0]=11.
//      - Stimulus: feed 11 x4.
//      - Response: match_cnt goes 1,2,3,3; cnt_sat=1 after the 3rd match.
//      - Build without MATCH_CNT_EN: match_cnt and cnt_sat stay 0.

Source files
------------

// File: rtl/symbol_seq_pkg.sv
// Shared constants, width helpers and step classification for the programmable
// symbol-sequence detector.
package symbol_seq_pkg;

   localparam int DEF_SYM_W   = 2;
   localparam int DEF_SEQ_LEN = 5;
   localparam int DEF_CNT_W   = 8;

   // Width of a progress index / length value that must hold 0..seq_len.
   function automatic int idx_width(input int seq_len);
      return $clog2(seq_len + 1);
   endfunction

   function automatic int slot_width(input int seq_len);
      return (seq_len > 1) ? $clog2(seq_len) : 1;
   endfunction

   typedef enum logic [2:0] {
      STEP_CFG,
      STEP_IDLE,
      STEP_HOLD,
      STEP_ADV,
      STEP_DONE,
      STEP_RESTART
   } step_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with all-ones flag; only compiled into builds that
// define MATCH_CNT_EN, so the default build carries no counter logic at all.
`ifdef MATCH_CNT_EN
module sat_counter #(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   logic [CNT_W-1:0] cnt_reg;

   assign cnt = cnt_reg;
   assign sat = &cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (inc && !sat) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

endmodule
`endif

// File: rtl/symbol_seq_fsm.sv
// Programmable symbol-sequence detector: run-time pattern, length and overlap mode.
// Define MATCH_CNT_EN to build the saturating match counter (match_cnt, cnt_sat).
module symbol_seq_fsm
   import symbol_seq_pkg::*;
#(
   parameter int SYM_W   = DEF_SYM_W,
   parameter int SEQ_LEN = DEF_SEQ_LEN,
   parameter int CNT_W   = DEF_CNT_W
)(
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            in_valid,
   input  logic [SYM_W-1:0]                in_sym,
   input  logic                            cfg_we,
   input  logic [slot_width(SEQ_LEN)-1:0]  cfg_idx,
   input  logic [SYM_W-1:0]                cfg_sym,
   input  logic                            cfg_len_we,
   input  logic [idx_width(SEQ_LEN)-1:0]   cfg_len,
   input  logic                            overlap_en,
   output logic                            match,
   output logic [idx_width(SEQ_LEN)-1:0]   state_out,
   output logic [CNT_W-1:0]                match_cnt,
   output logic                            cnt_sat
);

   localparam int                IDX_W      = idx_width(SEQ_LEN);
   localparam int                SLOT_W     = slot_width(SEQ_LEN);
   localparam logic [IDX_W-1:0]  LEN_MAX    = IDX_W'(SEQ_LEN);
   localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(SEQ_LEN);

   logic [SEQ_LEN-1:0][SYM_W-1:0] pat_vec;
   logic [IDX_W-1:0]              st_reg;
   logic [IDX_W-1:0]              len_reg;
   logic                          match_reg;

   logic                          cfg_any;
   logic                          idx_ok;
   logic [SYM_W-1:0]              cur_pat;
   logic                          hit;
   logic                          hit0;
   logic                          last;
   logic [IDX_W:0]                st_inc;
   logic [IDX_W-1:0]              restart;
   step_t                         step;

   assign cfg_any = cfg_we | cfg_len_we;
   assign idx_ok  = ({1'b0, cfg_idx} < SLOT_LIMIT);

   generate
      for (genvar gi = 0; gi < SEQ_LEN; gi++) begin : g_slot
         logic [SYM_W-1:0] pat_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pat_reg <= '0;
            end else if (cfg_we && idx_ok && (cfg_idx == SLOT_W'(gi))) begin
               pat_reg <= cfg_sym;
            end
         end

         assign pat_vec[gi] = pat_reg;
      end
   endgenerate

   always_comb begin
      cur_pat = pat_vec[0];
      for (int i = 1; i < SEQ_LEN; i++) begin
         if (st_reg == IDX_W'(i)) begin
            cur_pat = pat_vec[i];
         end
      end
   end

   assign hit    = (in_sym == cur_pat);
   assign hit0   = (in_sym == pat_vec[0]);
   assign st_inc = {1'b0, st_reg} + (IDX_W + 1)'(1);
   assign last   = (st_inc == {1'b0, len_reg});
   // A length-1 pattern completes on every hit, so progress never leaves 0.
   assign restart = (hit0 && (len_reg != IDX_W'(1))) ? IDX_W'(1) : '0;

   always_comb begin
      step = STEP_HOLD;
      if (cfg_any) begin
         step = STEP_CFG;
      end else if (len_reg == '0) begin
         step = STEP_IDLE;
      end else if (!in_valid) begin
         step = STEP_HOLD;
      end else if (hit && last) begin
         step = STEP_DONE;
      end else if (hit) begin
         step = STEP_ADV;
      end else begin
         step = STEP_RESTART;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_reg    <= '0;
         len_reg   <= LEN_MAX;
         match_reg <= 1'b0;
      end else begin
         match_reg <= (step == STEP_DONE);
         if (cfg_len_we) begin
            len_reg <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
         end
         case (step)
            STEP_CFG, STEP_IDLE: st_reg <= '0;
            STEP_HOLD:           st_reg <= st_reg;
            STEP_ADV:            st_reg <= st_inc[IDX_W-1:0];
            STEP_DONE:           st_reg <= overlap_en ? restart : '0;
            STEP_RESTART:        st_reg <= restart;
            default:             st_reg <= '0;
         endcase
      end
   end

   assign match     = match_reg;
   assign state_out = st_reg;

`ifdef MATCH_CNT_EN
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (match_reg),
      .cnt     (match_cnt),
      .sat     (cnt_sat)
   );
`else
   assign match_cnt = '0;
   assign cnt_sat   = 1'b0;
`endif

endmodule
